// File: rtl/bus_pkg.sv
// Shared definitions for the core/debug bus arbiter: state encoding, grant codes, error read data.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0]  GRANT_M0  = 2'b01;
  localparam logic [1:0]  GRANT_M1  = 2'b10;
  localparam logic [63:0] ERR_RDATA = '1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker: single requester wins, a tie goes to the one not granted last.
module rr_arbiter2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = GRANT_M0;
      2'b10:   grant = GRANT_M1;
      2'b11:   grant = last_grant ? GRANT_M0 : GRANT_M1;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter/sequencer (IDLE -> ACCESS -> RESP). Optional access timeout
// is enabled with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic              m0_err,
  output logic              m1_err,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_read,
  output logic              bus_write,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic [1:0]        grant,
  output logic              busy
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT must be in 2..255");
  end

  state_t     state;
  logic       owner;       // 0 = m0, 1 = m1
  logic       owner_we;
  logic       last_grant;
  logic [1:0] arb_grant;

  rr_arbiter2 u_rr (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      owner_we    <= 1'b0;
      last_grant  <= 1'b1;
      grant       <= '0;
      busy        <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      bus_address <= '0;
      bus_wdata   <= '0;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
`endif
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      m0_err <= 1'b0;
      m1_err <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (|arb_grant) begin
            owner       <= arb_grant[1];
            last_grant  <= arb_grant[1];
            grant       <= arb_grant;
            busy        <= 1'b1;
            owner_we    <= arb_grant[1] ? m1_we : m0_we;
            bus_address <= arb_grant[1] ? m1_addr : m0_addr;
            bus_wdata   <= arb_grant[1] ? m1_wdata : m0_wdata;
            bus_read    <= arb_grant[1] ? !m1_we : !m0_we;
            bus_write   <= arb_grant[1] ? m1_we : m0_we;
            state       <= ST_ACCESS;
`ifdef BUS_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        ST_ACCESS: begin
          // Ack and err are raised here so they are visible during the RESP cycle.
          if (bus_ready) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            state     <= ST_RESP;
            if (owner) begin
              m1_ack <= 1'b1;
              if (!owner_we) m1_rdata <= bus_rdata;
            end else begin
              m0_ack <= 1'b1;
              if (!owner_we) m0_rdata <= bus_rdata;
            end
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            state     <= ST_RESP;
            if (owner) begin
              m1_ack <= 1'b1;
              m1_err <= 1'b1;
              if (!owner_we) m1_rdata <= ERR_RDATA[DATA_W-1:0];
            end else begin
              m0_ack <= 1'b1;
              m0_err <= 1'b1;
              if (!owner_we) m0_rdata <= ERR_RDATA[DATA_W-1:0];
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          grant     <= '0;
          busy      <= 1'b0;
          bus_read  <= 1'b0;
          bus_write <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: cycle vector table plus directed multi-cycle sequences.
module tb_bus_arbiter;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 16;

  logic              clock, reset;
  logic              m0_req, m1_req, m0_we, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr, bus_address;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, bus_wdata, bus_rdata;
  logic              m0_ack, m1_ack, m0_err, m1_err, bus_read, bus_write, bus_ready, busy;
  logic [1:0]        grant;

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_err(m0_err), .m1_err(m1_err), .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_read(bus_read), .bus_write(bus_write), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .grant(grant), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    bus_ready = 1'b0; bus_rdata = '0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Each vector: inputs applied, one clock edge, then outputs compared.
  typedef struct {
    bit          rst;
    bit          r0, r1, rdy;
    logic [63:0] rd;
    logic [1:0]  g;
    bit          br, bw, a0, a1, by;
    logic [63:0] e0, e1;
  } vec_t;

  vec_t vt[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_addr = 64'h0000_0000_0000_1000; m1_addr = 64'h0000_0000_FFFF_0000;
    m0_wdata = 64'h55; m1_wdata = 64'h3FF;
    reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    bus_ready = 1'b0; bus_rdata = '0;

    //            rst r0 r1 rdy rd                  g      br bw a0 a1 by e0            e1
    vt[0]  = '{1, 1, 0, 0, 64'h0,            2'b01, 1, 0, 0, 0, 1, 64'h0,        64'h0};
    vt[1]  = '{0, 1, 0, 1, 64'hDEAD_BEEF,    2'b01, 0, 0, 1, 0, 1, 64'hDEAD_BEEF, 64'h0};
    vt[2]  = '{0, 0, 0, 0, 64'h0,            2'b00, 0, 0, 0, 0, 0, 64'hDEAD_BEEF, 64'h0};
    vt[3]  = '{1, 1, 1, 1, 64'h1111,         2'b01, 1, 0, 0, 0, 1, 64'h0,        64'h0};
    vt[4]  = '{0, 1, 1, 1, 64'h1111,         2'b01, 0, 0, 1, 0, 1, 64'h1111,     64'h0};
    vt[5]  = '{0, 1, 1, 1, 64'h2222,         2'b00, 0, 0, 0, 0, 0, 64'h1111,     64'h0};
    vt[6]  = '{0, 1, 1, 1, 64'h2222,         2'b10, 1, 0, 0, 0, 1, 64'h1111,     64'h0};
    vt[7]  = '{0, 1, 1, 1, 64'h2222,         2'b10, 0, 0, 0, 1, 1, 64'h1111,     64'h2222};
    vt[8]  = '{0, 1, 1, 1, 64'h3333,         2'b00, 0, 0, 0, 0, 0, 64'h1111,     64'h2222};
    vt[9]  = '{0, 1, 1, 1, 64'h3333,         2'b01, 1, 0, 0, 0, 1, 64'h1111,     64'h2222};
    vt[10] = '{0, 1, 1, 1, 64'h3333,         2'b01, 0, 0, 1, 0, 1, 64'h3333,     64'h2222};
    vt[11] = '{0, 1, 1, 1, 64'h4444,         2'b00, 0, 0, 0, 0, 0, 64'h3333,     64'h2222};
    vt[12] = '{0, 1, 1, 1, 64'h4444,         2'b10, 1, 0, 0, 0, 1, 64'h3333,     64'h2222};
    vt[13] = '{0, 1, 1, 1, 64'h4444,         2'b10, 0, 0, 0, 1, 1, 64'h3333,     64'h4444};

    // Reset values while reset is held low
    #3;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_strobes", 64'({bus_read, bus_write}), 64'h0);
    chk("rst_acks", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'h0);
    chk("rst_addr", bus_address, 64'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 64'h0);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].rst) do_reset();
      m0_req = vt[i].r0; m1_req = vt[i].r1; bus_ready = vt[i].rdy; bus_rdata = vt[i].rd;
      step();
      chk($sformatf("v%0d_grant", i), 64'(grant), 64'(vt[i].g));
      chk($sformatf("v%0d_strobes", i), 64'({bus_read, bus_write}), 64'({vt[i].br, vt[i].bw}));
      chk($sformatf("v%0d_acks", i), 64'({m0_ack, m1_ack}), 64'({vt[i].a0, vt[i].a1}));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].by));
      chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vt[i].e0);
      chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vt[i].e1);
      if (vt[i].g == 2'b01) chk($sformatf("v%0d_addr", i), bus_address, m0_addr);
      if (vt[i].g == 2'b10) chk($sformatf("v%0d_addr", i), bus_address, m1_addr);
    end

    // m1 read to seed m1_rdata, then m1 write with 4 wait cycles
    do_reset();
    m1_req = 1'b1; m1_we = 1'b0; bus_ready = 1'b1; bus_rdata = 64'h1234;
    step(); step();
    chk("seed_m1_ack", 64'(m1_ack), 64'h1);
    chk("seed_m1_rdata", m1_rdata, 64'h1234);
    m1_req = 1'b0; bus_ready = 1'b0; bus_rdata = 64'hBAD;
    step();
    begin
      int wcnt = 0;
      bit got = 1'b0;
      bit overlap = 1'b0;
      m1_req = 1'b1; m1_we = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
        step();
        if (bus_write) wcnt++;
        if (bus_write && bus_read) overlap = 1'b1;
        if (wcnt == 1 && bus_write) begin
          chk("wr_wdata", bus_wdata, 64'h3FF);
          chk("wr_addr", bus_address, 64'h0000_0000_FFFF_0000);
        end
        if (m1_ack) got = 1'b1;
        bus_ready = (wcnt >= 5);
      end
      chk("wr_ack", 64'(got), 64'h1);
      chk("wr_cycles", 64'(wcnt), 64'd5);
      chk("wr_overlap", 64'(overlap), 64'h0);
      chk("wr_m1_rdata", m1_rdata, 64'h1234);
      chk("wr_err", 64'(m1_err), 64'h0);
      m1_req = 1'b0; m1_we = 1'b0; bus_ready = 1'b0;
      step();
    end

    // m0 read against a slave that never answers
    do_reset();
    m0_req = 1'b1; bus_ready = 1'b0;
    begin
      int acc = 0;
      int acks = 0;
      bit done = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      for (int c = 0; c < 40 && !done; c++) begin
        step();
        if (bus_read) acc++;
        if (m0_ack) done = 1'b1;
      end
      chk("to_ack", 64'(done), 64'h1);
      chk("to_access_cycles", 64'(acc), 64'(TIMEOUT));
      chk("to_err", 64'(m0_err), 64'h1);
      chk("to_rdata", m0_rdata, '1);
`else
      for (int c = 0; c < 40; c++) begin
        step();
        if (m0_ack || m1_ack) acks++;
      end
      chk("noto_acks", 64'(acks), 64'h0);
      chk("noto_busy", 64'(busy), 64'h1);
      chk("noto_read", 64'(bus_read), 64'h1);
      chk("noto_err", 64'({m0_err, m1_err}), 64'h0);
`endif
    end

    // Reset during the third ACCESS cycle, with m1 pending
    do_reset();
    m0_req = 1'b1; bus_ready = 1'b0;
    step();
    m1_req = 1'b1;
    step(); step();
    chk("mid_in_access", 64'({grant, bus_read}), 64'({2'b01, 1'b1}));
    #2;
    reset = 1'b0; m0_req = 1'b0;
    #1;
    chk("mid_grant", 64'(grant), 64'h0);
    chk("mid_strobes", 64'({bus_read, bus_write}), 64'h0);
    chk("mid_busy", 64'(busy), 64'h0);
    chk("mid_ack", 64'({m0_ack, m1_ack}), 64'h0);
    chk("mid_addr", bus_address, 64'h0);
    step();
    reset = 1'b1;
    step();
    chk("post_grant_m1", 64'(grant), 64'(2'b10));
    chk("post_addr", bus_address, 64'h0000_0000_FFFF_0000);
    bus_ready = 1'b1; bus_rdata = 64'h77;
    step();
    chk("post_acks", 64'({m0_ack, m1_ack}), 64'(2'b01));
    chk("post_m1_rdata", m1_rdata, 64'h77);
    m1_req = 1'b0; bus_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
